// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg
//   Shared types and sizing helpers for the multiplier scheduler slice.
//   - state_t        : scheduler FSM encoding (3 bits)
//   - *_DEF          : default sizing used when the scheduler is not overridden
//   - IDX_W / CNT_W  : requester-index and timeout-counter widths at default sizing
//   - idx_w / cnt_w  : the same widths computed for arbitrary parameters
package mult_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 5;
    localparam int TIMEOUT_DEF = 64;

    // The multiplier must drop ready within this many cycles of entering S_WAIT_LOW.
    localparam int WAIT_LOW_LIMIT = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int IDX_W = idx_w(NREQ_DEF);
    localparam int CNT_W = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at slot ptr and
//   ascends with wrap-around; the first set request bit wins.
//   Ports:
//     req     in  NREQ   request vector
//     ptr     in  IDX_W  highest-priority slot (must be < NREQ)
//     gnt     out NREQ   one-hot winner (0 when no request)
//     gnt_idx out IDX_W  binary winner index (0 when no request)
//     any_req out 1      at least one request is set
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;

    // Walk from the farthest offset down to offset 0 so that the slot
    // closest to ptr overwrites any earlier candidate.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sum     = '0;
        slot    = '0;
        any_req = |req;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end
            slot = sum[IDX_W-1:0];
            if (req[slot]) begin
                gnt     = NREQ'(1) << slot;
                gnt_idx = slot;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler
//   Shares one sequential multiplier among NREQ requesters. A round-robin
//   winner's operands are latched, the multiplier is started, and once its
//   ready has fallen and risen again the product is returned to the winner.
//   Ports:
//     clk, reset_n              clock (rising edge), async active-low reset
//     req/req_a/req_b           per-slot request and packed operands
//     grant                     one-hot pulse: operands of that slot captured
//     rsp_valid/rsp_product     one-hot response pulse and held product
//     busy                      scheduler not idle
//     err                       sticky multiplier timeout flag
//     mul_start/mul_a/mul_b     multiplier start pulse and latched operands
//     mul_ready/mul_product     multiplier status and result
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    busy,
    output logic                    err,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_ready,
    input  logic [2*WIDTH-1:0]      mul_product
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(TIMEOUT);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, winner, arb_idx;
    logic [NREQ-1:0]  arb_gnt;
    logic             arb_any;
    logic [CW-1:0]    cnt;
    logic             take, mul_done, tmo;
    logic [WIDTH-1:0] a_slot [NREQ];
    logic [WIDTH-1:0] b_slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign a_slot[i] = req_a[i*WIDTH +: WIDTH];
        assign b_slot[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // A job is only accepted while the multiplier reports ready.
    assign take     = (state == S_IDLE) && arb_any && mul_ready;
    assign mul_done = (state == S_WAIT_HIGH) && mul_ready;

    // Two abort causes: ready never fell after start, or it stayed low too long.
    always_comb begin
        tmo = 1'b0;
        if ((state == S_WAIT_LOW) && mul_ready &&
            (cnt >= CW'(WAIT_LOW_LIMIT - 1))) begin
            tmo = 1'b1;
        end
        if ((state == S_WAIT_HIGH) && !mul_ready &&
            (cnt == CW'(TIMEOUT - 1))) begin
            tmo = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (take) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (tmo)             state_nxt = S_IDLE;
                else if (!mul_ready) state_nxt = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (mul_done)        state_nxt = S_DONE;
                else if (tmo)        state_nxt = S_IDLE;
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        grant     = take ? arb_gnt : '0;
        rsp_valid = (state == S_DONE) ? (NREQ'(1) << winner) : '0;
        mul_start = (state == S_START);
        busy      = (state != S_IDLE);
    end

    // Wait-phase cycle counter; restarts from zero on every job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if ((state == S_WAIT_LOW) || (state == S_WAIT_HIGH)) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Operand/winner latches, response capture, round-robin pointer, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a       <= '0;
            mul_b       <= '0;
            winner      <= '0;
            rsp_product <= '0;
            ptr         <= '0;
            err         <= 1'b0;
        end else begin
            if (take) begin
                mul_a  <= a_slot[arb_idx];
                mul_b  <= b_slot[arb_idx];
                winner <= arb_idx;
            end
            if (mul_done) begin
                rsp_product <= mul_product;
            end
            if (tmo) begin
                err <= 1'b1;
            end
            // Completed or aborted, the winner drops to lowest priority.
            if ((state == S_DONE) || tmo) begin
                ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule
